// File: rtl/seq_timer_pkg.sv
// Shared definitions for the sequencing delay timer bank: channel modes,
// per-channel state encoding and mode normalisation.
package seq_timer_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_LEVEL    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_PULSE    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_PERIODIC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } ch_state_t;

    // The reserved encoding 2'b11 behaves as LEVEL.
    function automatic logic [MODE_W-1:0] norm_mode(input logic [MODE_W-1:0] mode);
        return (mode == 2'b11) ? MODE_LEVEL : mode;
    endfunction

endpackage

// File: rtl/seq_dly_timer_ch.sv
// One delay-timer channel: counts shared ticks after enable, then flags
// timeout as a held level, a single pulse, or a periodic pulse train.
module seq_dly_timer_ch
    import seq_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_in,
    input  logic              iRst_n,
    input  logic              tick,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  dly_time,
    output logic              timeout,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);

    ch_state_t         state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d, mode_act;
    logic [CNT_W-1:0]  count_d;
    logic              timeout_d;
    logic              busy_d;
    logic              step;

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LEVEL;
            count   <= '0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count   <= count_d;
            timeout <= timeout_d;
            busy    <= busy_d;
        end
    end

    // Next state and registered outputs; disable overrides everything.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count;
        timeout_d = 1'b0;
        mode_act  = mode_q;
        step      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (en) begin
                    state_d  = ST_RUN;
                    mode_d   = norm_mode(mode);
                    mode_act = norm_mode(mode);
                    step     = tick;
                end
            end
            ST_RUN:  step = tick;
            ST_DONE: timeout_d = (mode_q != MODE_PULSE);
            default: state_d = ST_IDLE;
        endcase

        // Delay is compared live, so a lowered delay expires on the next tick.
        if (step) begin
            if (count < dly_time) begin
                count_d = count + CNT_W'(1);
            end else begin
                timeout_d = 1'b1;
                if (mode_act == MODE_PERIODIC) begin
                    count_d = '0;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end

        if (!en) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            timeout_d = 1'b0;
        end

        busy_d = (state_d == ST_RUN);
    end

endmodule

// File: rtl/seq_dly_timer_bank.sv
// Multi-channel delay timer bank for power/reset sequencing: one shared
// prescaler feeding NUM_CH independent delay channels.
module seq_dly_timer_bank
    import seq_timer_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                     clk_in,
    input  logic                     iRst_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [MODE_W*NUM_CH-1:0] ch_mode,
    input  logic [CNT_W*NUM_CH-1:0]  ch_dly_time,
    output logic [NUM_CH-1:0]        ch_timeout,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [CNT_W*NUM_CH-1:0]  ch_count,
    output logic                     tick
);

    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt, ps_nxt;

    always_comb begin
        ps_nxt = (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
    end

    // tick is registered so it reads PRESCALE-1 in the same cycle as ps_cnt.
    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else begin
            ps_cnt <= ps_nxt;
            tick   <= (ps_nxt == PS_LAST);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        seq_dly_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_in   (clk_in),
            .iRst_n   (iRst_n),
            .tick     (tick),
            .en       (ch_en[i]),
            .mode     (ch_mode[MODE_W*i +: MODE_W]),
            .dly_time (ch_dly_time[CNT_W*i +: CNT_W]),
            .timeout  (ch_timeout[i]),
            .busy     (ch_busy[i]),
            .count    (ch_count[CNT_W*i +: CNT_W])
        );
    end

endmodule
